// File: rtl/hssi_ets_fp_pkg.sv
// Shared types and widths for the HSSI egress-timestamp fingerprint scheduler.
package hssi_ets_fp_pkg;

   localparam int TS_WIDTH    = 96;
   localparam int AGE_WIDTH   = 8;
   localparam int CNT_WIDTH   = 16;
   // Wide enough for the largest supported requester count (8).
   localparam int OWNER_WIDTH = 3;

   localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

   typedef struct packed {
      logic                   valid;
      logic [OWNER_WIDTH-1:0] owner;
      logic [AGE_WIDTH-1:0]   age;
   } fp_entry_t;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/hssi_ets_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester after the last winner.
module hssi_ets_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req,
   input  logic                     en,
   input  logic                     accept,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx
);

   localparam int PW = $clog2(N_REQ);
   localparam logic [PW:0] NR = (PW+1)'(N_REQ);

   logic [PW-1:0] ptr;
   logic [PW:0]   cand;
   logic          found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, ptr} + (PW+1)'(k);
         if (cand >= NR) cand = cand - NR;
         if (en && !found && req[cand[PW-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[PW-1:0];
         end
      end
      if (found) grant[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      ptr <= '0;
      else if (accept) ptr <= grant_idx;
   end

endmodule

// File: rtl/hssi_ets_fp_scheduler.sv
// Shares one ETS fingerprint space between TX requesters: allocation, owner
// routing of returned timestamps, age-based retirement and stray accounting.
module hssi_ets_fp_scheduler
   import hssi_ets_fp_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int FP_WIDTH = 8,
   parameter int DEPTH    = 16,
   parameter int TICK_DIV = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   output logic [FP_WIDTH-1:0]        alloc_fp,
   input  logic                       ts_valid,
   input  logic [FP_WIDTH-1:0]        ts_fp,
   input  logic [TS_WIDTH-1:0]        ts_data,
   output logic [N_REQ-1:0]           ts_out_valid,
   output logic [FP_WIDTH-1:0]        ts_out_fp,
   output logic [TS_WIDTH-1:0]        ts_out_data,
   output logic [N_REQ-1:0]           timeout_pulse,
   output logic [FP_WIDTH-1:0]        timeout_fp,
   input  logic [AGE_WIDTH-1:0]       cfg_timeout,
   output logic [$clog2(DEPTH+1)-1:0] outstanding,
   output logic [CNT_WIDTH-1:0]       stray_cnt,
   output logic [CNT_WIDTH-1:0]       timeout_cnt
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = $clog2(N_REQ);
   localparam int OW = $clog2(DEPTH+1);
   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

   fp_entry_t     tbl [DEPTH];
   logic [DW-1:0] presc;
   logic          tick;
   logic          any_free;
   logic [IW-1:0] free_idx;
   logic [PW-1:0] grant_idx;
   logic          alloc_go;
   logic          ts_in_range;
   logic [IW-1:0] ret_idx;
   logic          ret_hit;
   logic          stray;
   logic          exp_go;
   logic [IW-1:0] exp_idx;

   // Down-counting prescaler; terminal count at zero produces the age tick.
   assign tick = (presc == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    presc <= '0;
      else if (tick) presc <= DW'(TICK_DIV - 1);
      else           presc <= presc - 1'b1;
   end

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!tbl[i].valid) begin
            any_free = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   hssi_ets_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .en        (any_free),
      .accept    (alloc_go),
      .grant     (req_ready),
      .grant_idx (grant_idx)
   );

   assign alloc_go = |(req_valid & req_ready);
   assign alloc_fp = FP_WIDTH'(free_idx);

   assign ts_in_range = ({1'b0, ts_fp} < (FP_WIDTH+1)'(DEPTH));
   assign ret_idx     = ts_fp[IW-1:0];
   assign ret_hit     = ts_valid && ts_in_range && tbl[ret_idx].valid;
   assign stray       = ts_valid && !ret_hit;

   // A return to an entry masks its expiry so the timestamp is still delivered.
   always_comb begin
      exp_go  = 1'b0;
      exp_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (tbl[i].valid && (cfg_timeout != '0) && (tbl[i].age >= cfg_timeout) &&
             !(ret_hit && (ret_idx == IW'(i)))) begin
            exp_go  = 1'b1;
            exp_idx = IW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if ((ret_hit && (ret_idx == IW'(i))) || (exp_go && (exp_idx == IW'(i)))) begin
               tbl[i].valid <= 1'b0;
            end else if (alloc_go && (free_idx == IW'(i))) begin
               tbl[i].valid <= 1'b1;
               tbl[i].owner <= OWNER_WIDTH'(grant_idx);
               tbl[i].age   <= '0;
            end else if (tick && tbl[i].valid && (tbl[i].age != AGE_MAX)) begin
               tbl[i].age <= tbl[i].age + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_out_valid  <= '0;
         ts_out_fp     <= '0;
         ts_out_data   <= '0;
         timeout_pulse <= '0;
         timeout_fp    <= '0;
         stray_cnt     <= '0;
         timeout_cnt   <= '0;
         outstanding   <= '0;
      end else begin
         ts_out_valid  <= ret_hit ? (ONE << tbl[ret_idx].owner) : '0;
         timeout_pulse <= exp_go  ? (ONE << tbl[exp_idx].owner) : '0;
         if (ret_hit) begin
            ts_out_fp   <= ts_fp;
            ts_out_data <= ts_data;
         end
         if (exp_go) begin
            timeout_fp  <= FP_WIDTH'(exp_idx);
            timeout_cnt <= sat_inc(timeout_cnt);
         end
         if (stray) stray_cnt <= sat_inc(stray_cnt);
         outstanding <= outstanding + OW'(alloc_go) - OW'(ret_hit) - OW'(exp_go);
      end
   end

endmodule
